execute_port1_wb_queue: RTL and testbench

//  Result queue directly downstream of ALU1 execute port. Captures every valid ALU1/divider

---
 rtl/execute_port1_wb_queue.sv | 103 ++++++++++
 tb/tb_execute_port1_wb_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_port1_wb_queue.sv
// In-order result queue between the ALU1/divider result bus and the writeback bus.
// Absorbs writeback stalls; raises a lock to issue before the queue can overflow.
module execute_port1_wb_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DEPTH_N     = 3,
    parameter int unsigned LOCK_MARGIN = 3
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iFREE_EX,
    input  logic               iEX_ALU1_VALID,
    input  logic [5:0]         iEX_ALU1_COMMIT_TAG,
    input  logic               iEX_ALU1_SYSREG,
    input  logic [5:0]         iEX_ALU1_DEST_REGNAME,
    input  logic               iEX_ALU1_WRITEBACK,
    input  logic [31:0]        iEX_ALU1_DATA,
    input  logic [4:0]         iEX_ALU1_FLAG,
    input  logic               iEX_ALU1_FLAGS_WB,
    input  logic [3:0]         iEX_ALU1_FLAGS_REGNAME,
    output logic               oEX_ALU1_LOCK,
    output logic               oWB_VALID,
    input  logic               iWB_BUSY,
    output logic [5:0]         oWB_COMMIT_TAG,
    output logic               oWB_SYSREG,
    output logic [5:0]         oWB_DEST_REGNAME,
    output logic               oWB_WRITEBACK,
    output logic [31:0]        oWB_DATA,
    output logic [4:0]         oWB_FLAG,
    output logic               oWB_FLAGS_WB,
    output logic [3:0]         oWB_FLAGS_REGNAME,
    output logic [DEPTH_N:0]   oCOUNT,
    output logic               oOVERFLOW
);

    localparam int unsigned        ENTRY_W  = 56;
    localparam logic [DEPTH_N:0]   L_DEPTH  = (DEPTH_N + 1)'(DEPTH);
    localparam logic [DEPTH_N:0]   L_MARGIN = (DEPTH_N + 1)'(LOCK_MARGIN);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [DEPTH_N-1:0] r_wr_ptr;
    logic [DEPTH_N-1:0] r_rd_ptr;
    logic [DEPTH_N:0]   r_count;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_DEPTH);
    assign w_pop   = !w_empty && !iWB_BUSY;
    // A full queue still accepts a result when the head leaves in the same cycle.
    assign w_push  = iEX_ALU1_VALID && (!w_full || w_pop);

    assign w_wr_entry = {iEX_ALU1_COMMIT_TAG, iEX_ALU1_SYSREG, iEX_ALU1_DEST_REGNAME,
                         iEX_ALU1_WRITEBACK, iEX_ALU1_DATA, iEX_ALU1_FLAG,
                         iEX_ALU1_FLAGS_WB, iEX_ALU1_FLAGS_REGNAME};

    // Writes during reset/flush are harmless: the pointers are cleared that same edge.
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET || iFREE_EX) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (iEX_ALU1_VALID && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign {oWB_COMMIT_TAG, oWB_SYSREG, oWB_DEST_REGNAME, oWB_WRITEBACK,
            oWB_DATA, oWB_FLAG, oWB_FLAGS_WB, oWB_FLAGS_REGNAME} = w_head;

    assign oWB_VALID     = !w_empty;
    assign oCOUNT        = r_count;
    assign oOVERFLOW     = r_overflow;
    assign oEX_ALU1_LOCK = (L_DEPTH - r_count) <= L_MARGIN;

endmodule

// File: tb/tb_execute_port1_wb_queue.sv
// Bench for execute_port1_wb_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_execute_port1_wb_queue;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        free_ex;
    logic        in_valid;
    logic [5:0]  in_tag;
    logic        in_sysreg;
    logic [5:0]  in_regname;
    logic        in_wb;
    logic [31:0] in_data;
    logic [4:0]  in_flag;
    logic        in_flagwb;
    logic [3:0]  in_flagreg;
    logic        busy;

    logic        lock;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic        wb_sysreg;
    logic [5:0]  wb_regname;
    logic        wb_wb;
    logic [31:0] wb_data;
    logic [4:0]  wb_flag;
    logic        wb_flagwb;
    logic [3:0]  wb_flagreg;
    logic [3:0]  count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    execute_port1_wb_queue #(.DEPTH(8), .DEPTH_N(3), .LOCK_MARGIN(3)) dut (
        .iCLOCK(clk), .inRESET(rstn), .iFREE_EX(free_ex),
        .iEX_ALU1_VALID(in_valid), .iEX_ALU1_COMMIT_TAG(in_tag),
        .iEX_ALU1_SYSREG(in_sysreg), .iEX_ALU1_DEST_REGNAME(in_regname),
        .iEX_ALU1_WRITEBACK(in_wb), .iEX_ALU1_DATA(in_data),
        .iEX_ALU1_FLAG(in_flag), .iEX_ALU1_FLAGS_WB(in_flagwb),
        .iEX_ALU1_FLAGS_REGNAME(in_flagreg),
        .oEX_ALU1_LOCK(lock), .oWB_VALID(wb_valid), .iWB_BUSY(busy),
        .oWB_COMMIT_TAG(wb_tag), .oWB_SYSREG(wb_sysreg),
        .oWB_DEST_REGNAME(wb_regname), .oWB_WRITEBACK(wb_wb),
        .oWB_DATA(wb_data), .oWB_FLAG(wb_flag), .oWB_FLAGS_WB(wb_flagwb),
        .oWB_FLAGS_REGNAME(wb_flagreg), .oCOUNT(count), .oOVERFLOW(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of 56-bit result records.
    logic [55:0] mq[$];
    logic        m_ovf     = 1'b0;
    logic        m_started = 1'b0;
    logic [5:0]  out_tags[$];

    always @(posedge clk) begin
        logic        do_pop;
        m_started = 1'b1;
        if (!rstn || free_ex) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop = (mq.size() > 0) && !busy;
            if (do_pop) begin
                out_tags.push_back(mq[0][55:50]);
                void'(mq.pop_front());
            end
            if (in_valid) begin
                if (mq.size() < DEPTH)
                    mq.push_back({in_tag, in_sysreg, in_regname, in_wb, in_data,
                                  in_flag, in_flagwb, in_flagreg});
                else
                    m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [55:0] exp_head;
        int          n;
        if (m_started) begin
            n = mq.size();
            exp_head = (n > 0) ? mq[0] : 56'd0;
            check("valid", 64'(wb_valid), 64'(n > 0));
            check("count", 64'(count), 64'(n));
            check("lock", 64'(lock), 64'((DEPTH - n) <= MARGIN));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("head", 64'({wb_tag, wb_sysreg, wb_regname, wb_wb, wb_data,
                               wb_flag, wb_flagwb, wb_flagreg}), 64'(exp_head));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [5:0] tag, input logic [31:0] data);
        in_valid   = v;
        in_tag     = tag;
        in_data    = data;
        in_sysreg  = tag[0];
        in_regname = tag ^ 6'h2A;
        in_wb      = tag[1];
        in_flag    = tag[4:0];
        in_flagwb  = tag[2];
        in_flagreg = tag[3:0];
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] sent[$];
        int         guard;
        rstn    = 1'b0;
        free_ex = 1'b0;
        busy    = 1'b0;
        set_in(1'b1, 6'h11, 32'h1234_5678);

        // Reset held with valid inputs present.
        tick(); tick();
        at_neg();
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_lock", 64'(lock), 64'd0);
        rstn = 1'b1;
        set_in(1'b0, 6'h0, 32'h0);
        tick();

        // Single result: visible exactly one cycle after capture.
        set_in(1'b1, 6'h05, 32'hDEADBEEF);
        at_neg();
        check("single_pre_valid", 64'(wb_valid), 64'd0);
        tick();
        set_in(1'b0, 6'h0, 32'h0);
        at_neg();
        check("single_valid", 64'(wb_valid), 64'd1);
        check("single_tag", 64'(wb_tag), 64'h05);
        check("single_data", 64'(wb_data), 64'hDEADBEEF);
        check("single_count1", 64'(count), 64'd1);
        tick();
        at_neg();
        check("single_count0", 64'(count), 64'd0);
        check("single_empty", 64'(wb_valid), 64'd0);

        // Lock threshold while stalled.
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 6'(10 + i), 32'hA000_0000 + 32'(i));
            tick();
            if (i == 3) check("lock_at4", 64'(lock), 64'd0);
        end
        set_in(1'b0, 6'h0, 32'h0);
        check("lock_at5", 64'(lock), 64'd1);
        check("count5", 64'(count), 64'd5);
        check("head_stable", 64'(wb_tag), 64'd10);
        busy = 1'b0;
        tick();
        check("lock_fall", 64'(lock), 64'd0);
        check("drain_head", 64'(wb_tag), 64'd11);
        for (int i = 0; i < 5; i++) tick();
        check("drain_empty", 64'(count), 64'd0);

        // Fill to full, then push+pop when full, then a dropped push.
        busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 6'(20 + i), 32'hB000_0000 + 32'(i));
            tick();
        end
        check("full_count", 64'(count), 64'd8);
        busy = 1'b0;
        set_in(1'b1, 6'd28, 32'hB000_0008);
        tick();
        check("pushpop_count", 64'(count), 64'd8);
        check("pushpop_ovf", 64'(overflow), 64'd0);
        check("pushpop_head", 64'(wb_tag), 64'd21);
        busy = 1'b1;
        set_in(1'b1, 6'd29, 32'hB000_0009);
        tick();
        set_in(1'b0, 6'h0, 32'h0);
        check("drop_ovf", 64'(overflow), 64'd1);
        check("drop_count", 64'(count), 64'd8);

        // Flush clears the overflow, then flush with a concurrent push at count=6.
        free_ex = 1'b1;
        tick();
        free_ex = 1'b0;
        check("flush1_count", 64'(count), 64'd0);
        check("flush1_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 6'(40 + i), 32'hC000_0000 + 32'(i));
            tick();
        end
        check("pre_flush_count", 64'(count), 64'd6);
        set_in(1'b1, 6'd63, 32'hFFFF_FFFF);
        free_ex = 1'b1;
        tick();
        free_ex = 1'b0;
        set_in(1'b0, 6'h0, 32'h0);
        check("flush2_count", 64'(count), 64'd0);
        check("flush2_valid", 64'(wb_valid), 64'd0);
        check("flush2_ovf", 64'(overflow), 64'd0);
        tick();
        check("flush2_absent", 64'(count), 64'd0);

        // Wrap: 20 results under random stalls, honouring the issue lock.
        out_tags.delete();
        guard = 0;
        while (sent.size() < 20 && guard < 500) begin
            busy = 1'($urandom_range(0, 1));
            if (!lock) begin
                set_in(1'b1, 6'(sent.size() + 1), $urandom);
                sent.push_back(6'(sent.size() + 1));
            end else begin
                set_in(1'b0, 6'h0, 32'h0);
            end
            tick();
            guard++;
        end
        set_in(1'b0, 6'h0, 32'h0);
        busy = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("wrap_sent", 64'(sent.size()), 64'd20);
        check("wrap_received", 64'(out_tags.size()), 64'd20);
        for (int i = 0; i < 20 && i < out_tags.size() && i < sent.size(); i++)
            check("wrap_order", 64'(out_tags[i]), 64'(sent[i]));
        check("wrap_ovf", 64'(overflow), 64'd0);
        check("wrap_empty", 64'(count), 64'd0);

        at_neg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
